// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan decoder.
// Patterns are written {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD decode.
// Unknown patterns give BCD_INVALID with valid_o low.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] bcd_o,
  output logic       valid_o
);

  always_comb begin
    bcd_o   = BCD_INVALID;
    valid_o = 1'b1;
    unique case (pat_i)
      SEG_0:   bcd_o = 4'd0;
      SEG_1:   bcd_o = 4'd1;
      SEG_2:   bcd_o = 4'd2;
      SEG_3:   bcd_o = 4'd3;
      SEG_4:   bcd_o = 4'd4;
      SEG_5:   bcd_o = 4'd5;
      SEG_6:   bcd_o = 4'd6;
      SEG_7:   bcd_o = 4'd7;
      SEG_8:   bcd_o = 4'd8;
      SEG_9:   bcd_o = 4'd9;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receives a scanned 7-segment bus, settles each digit window
// and assembles complete BCD frames with a one-cycle strobe.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a,
  input  logic                    b,
  input  logic                    c,
  input  logic                    d,
  input  logic                    e,
  input  logic                    f,
  input  logic                    g,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    frame_err
);

  localparam int SW = NUM_DIGITS + 7;
  localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

  logic [6:0]              seg;
  logic [SW-1:0]           sample;
  logic [3:0]              dec_bcd;
  logic                    dec_ok;
  logic                    onehot;
  logic                    same;
  logic                    enter;
  logic                    cap;
  logic                    prev_all;

  state_t                  state_q, state_d;
  logic [SW-1:0]           prev_q;
  logic [3:0]              count_q, count_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   serr_q, serr_d;
  logic                    go_q, go_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   derr_q, derr_d;
  logic                    fv_q, fv_d;
  logic                    ferr_q, ferr_d;

  assign seg    = {g, f, e, d, c, b, a};
  assign sample = {dig_sel, seg};

  seg7_pattern_decode u_dec (
    .pat_i   (seg),
    .bcd_o   (dec_bcd),
    .valid_o (dec_ok)
  );

  always_comb begin
    onehot  = $onehot(dig_sel);
    same    = (sample == prev_q);
    state_d = state_q;
    count_d = count_q;
    enter   = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      IDLE:   enter = 1'b1;
      SETTLE: begin
        if (!onehot) begin
          state_d = IDLE;
        end else if (same) begin
          count_d = count_q + 4'd1;
          if (count_d == STABLE_C) begin
            cap     = 1'b1;
            state_d = HOLD;
          end
        end else begin
          enter = 1'b1;
        end
      end
      HOLD:    enter = !same;
      default: state_d = IDLE;
    endcase
    // Fresh one-hot window: a single-cycle stability need captures at once.
    if (enter) begin
      if (!onehot) begin
        state_d = IDLE;
      end else if (STABLE_C == 4'd1) begin
        cap     = 1'b1;
        count_d = 4'd1;
        state_d = HOLD;
      end else begin
        count_d = 4'd1;
        state_d = SETTLE;
      end
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    serr_d   = serr_q;
    mask_d   = mask_q;
    go_d     = 1'b0;
    prev_all = 1'b1;
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      prev_all = prev_all & mask_q[i];
    end
    if (cap) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (dig_sel[i]) begin
          shadow_d[4*i +: 4] = dec_bcd;
          serr_d[i]          = !dec_ok;
          mask_d[i]          = 1'b1;
        end
      end
      if (dig_sel[NUM_DIGITS-1]) begin
        go_d   = prev_all;
        mask_d = '0;
      end
    end
  end

  always_comb begin
    bcd_d  = bcd_q;
    derr_d = derr_q;
    ferr_d = ferr_q;
    fv_d   = 1'b0;
    if (go_q) begin
      bcd_d  = shadow_q;
      derr_d = serr_q;
      ferr_d = |serr_q;
      fv_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      count_q  <= '0;
      mask_q   <= '0;
      shadow_q <= '0;
      serr_q   <= '0;
      go_q     <= 1'b0;
      bcd_q    <= '0;
      derr_q   <= '0;
      fv_q     <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= sample;
      count_q  <= count_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      serr_q   <= serr_d;
      go_q     <= go_d;
      bcd_q    <= bcd_d;
      derr_q   <= derr_d;
      fv_q     <= fv_d;
      ferr_q   <= ferr_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_err   = derr_q;
  assign frame_valid = fv_q;
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder, NUM_DIGITS=4, STABLE_CYCLES=2.
// Table of full scans plus hand sequences for multi-cycle corners.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a, b, c, d, e, f, g;
  logic [3:0]  dig_sel;
  logic [15:0] bcd_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .e           (e),
    .f           (f),
    .g           (g),
    .dig_sel     (dig_sel),
    .bcd_out     (bcd_out),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  always @(negedge clk) if (frame_valid === 1'b1) pulses++;

  typedef struct {
    logic [27:0] pats;
    int          hold;
    logic [15:0] exp_bcd;
    logic [3:0]  exp_err;
    logic        exp_ferr;
    int          exp_pulses;
  } scan_t;

  scan_t vec [7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge; value is seen by exactly n rising edges.
  task automatic drive(input logic [3:0] sel, input logic [6:0] p,
                       input int n);
    dig_sel = sel;
    {g, f, e, d, c, b, a} = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan4(input logic [27:0] pats, input int n);
    for (int i = 0; i < 4; i++) begin
      drive(4'b0001 << i, pats[7*i +: 7], n);
    end
    drive(4'b0000, 7'h00, 3);
  endtask

  task automatic chk_out(input string name, input logic [15:0] eb,
                         input logic [3:0] ee, input logic ef);
    chk({name, ".bcd"}, 32'(bcd_out), 32'(eb));
    chk({name, ".err"}, 32'(digit_err), 32'(ee));
    chk({name, ".ferr"}, 32'(frame_err), 32'(ef));
  endtask

  initial begin
    int p0;
    dig_sel = '0;
    {g, f, e, d, c, b, a} = 7'h00;

    vec[0] = '{{7'h06, 7'h5B, 7'h4F, 7'h66}, 3, 16'h1234, 4'b0000, 1'b0, 1};
    vec[1] = '{{7'h06, 7'h5B, 7'h00, 7'h66}, 3, 16'h12F4, 4'b0010, 1'b1, 1};
    vec[2] = '{{7'h7D, 7'h07, 7'h7F, 7'h6F}, 1, 16'h12F4, 4'b0010, 1'b1, 0};
    vec[3] = '{{7'h7F, 7'h7F, 7'h7F, 7'h7F}, 2, 16'h8888, 4'b0000, 1'b0, 1};
    vec[4] = '{{7'h07, 7'h7D, 7'h6D, 7'h3F}, 5, 16'h7650, 4'b0000, 1'b0, 1};
    vec[5] = '{{7'h7E, 7'h06, 7'h06, 7'h06}, 2, 16'hF111, 4'b1000, 1'b1, 1};
    vec[6] = '{{7'h6F, 7'h6F, 7'h6F, 7'h00}, 1, 16'hF111, 4'b1000, 1'b1, 0};

    repeat (2) @(negedge clk);
    chk_out("reset", 16'h0000, 4'b0000, 1'b0);
    chk("reset.fv", 32'(frame_valid), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      p0 = pulses;
      scan4(vec[v].pats, vec[v].hold);
      chk_out($sformatf("vec%0d", v), vec[v].exp_bcd, vec[v].exp_err,
              vec[v].exp_ferr);
      chk($sformatf("vec%0d.pulses", v), 32'(pulses - p0),
          32'(vec[v].exp_pulses));
    end

    // Top digit captured without lower digits: frame discarded.
    p0 = pulses;
    drive(4'b0001, 7'h6F, 3);
    drive(4'b1000, 7'h7D, 3);
    drive(4'b0000, 7'h00, 3);
    chk_out("partial", 16'hF111, 4'b1000, 1'b1);
    chk("partial.pulses", 32'(pulses - p0), 32'd0);
    p0 = pulses;
    scan4({7'h7D, 7'h07, 7'h7F, 7'h6F}, 3);
    chk_out("after_partial", 16'h6789, 4'b0000, 1'b0);
    chk("after_partial.pulses", 32'(pulses - p0), 32'd1);

    // Two-hot select mid-scan, then exact strobe timing.
    p0 = pulses;
    drive(4'b0001, 7'h66, 3);
    drive(4'b0010, 7'h4F, 3);
    drive(4'b0011, 7'h7F, 5);
    drive(4'b0100, 7'h5B, 3);
    drive(4'b1000, 7'h06, 1);
    chk("twohot.fv_k", 32'(frame_valid), 32'd0);
    @(negedge clk);
    chk("twohot.fv_cap", 32'(frame_valid), 32'd0);
    @(negedge clk);
    chk("twohot.fv_out", 32'(frame_valid), 32'd1);
    chk_out("twohot", 16'h1234, 4'b0000, 1'b0);
    @(negedge clk);
    chk("twohot.fv_drop", 32'(frame_valid), 32'd0);
    drive(4'b0000, 7'h00, 3);
    chk("twohot.pulses", 32'(pulses - p0), 32'd1);

    // Reset mid-frame, then a top-digit-only scan must not emit.
    drive(4'b0001, 7'h3F, 3);
    drive(4'b0010, 7'h06, 3);
    drive(4'b0100, 7'h5B, 3);
    rst_n = 1'b0;
    #1;
    chk_out("midreset", 16'h0000, 4'b0000, 1'b0);
    chk("midreset.fv", 32'(frame_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses;
    drive(4'b1000, 7'h7F, 3);
    drive(4'b0000, 7'h00, 3);
    chk_out("post_reset_top", 16'h0000, 4'b0000, 1'b0);
    chk("post_reset_top.pulses", 32'(pulses - p0), 32'd0);
    p0 = pulses;
    scan4({7'h7F, 7'h07, 7'h7D, 7'h6D}, 3);
    chk_out("post_reset", 16'h8765, 4'b0000, 1'b0);
    chk("post_reset.pulses", 32'(pulses - p0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
